// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receiver with a 16x NCO oversampler, 2-of-3 majority bit
//            voting, optional parity, 1-2 stop bits and a show-ahead receive
//            FIFO. Errors are reported as single-cycle pulses.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous reset, active low
//            uart_rx      - asynchronous serial line, idle high
//            rdata        - FIFO head data (0 when empty)
//            rdata_vld    - FIFO not empty
//            rdata_rdy    - consumer accept; pop on vld && rdy
//            fifo_count   - FIFO occupancy
//            err_parity   - parity error pulse (frame discarded)
//            err_frame    - stop-bit error pulse (frame discarded)
//            err_overrun  - clean frame dropped because FIFO full
//            err_break    - break detected (only with UART_RX_BREAK_DET_EN)
//            uart_err     - OR of the four error pulses
// Config   : define UART_RX_BREAK_DET_EN to enable break detection and the
//            BREAK_WAIT state; otherwise an all-zero frame is a frame error.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter real CLK_FREQ   = 100e6,
  parameter real BAUD_RATE  = 115200,
  parameter int  NCO_WIDTH  = 16,
  parameter int  DATA_BITS  = 8,
  parameter int  PARITY     = 1,
  parameter int  STOP_BITS  = 1,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            uart_rx,
  output logic [DATA_BITS-1:0]            rdata,
  output logic                            rdata_vld,
  input  logic                            rdata_rdy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            err_parity,
  output logic                            err_frame,
  output logic                            err_overrun,
  output logic                            err_break,
  output logic                            uart_err
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [NCO_WIDTH-1:0] c_inc =
    NCO_WIDTH'($rtoi(16.0 * BAUD_RATE * (2.0 ** NCO_WIDTH) / CLK_FREQ + 0.5));
  localparam logic [2:0] c_last_bit  = 3'(DATA_BITS - 1);
  localparam logic       c_last_stop = 1'(STOP_BITS - 1);
  localparam logic       c_odd       = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_RX_BREAK_DET_EN
    , ST_BREAK_WAIT = 3'd5
`endif
  } state_t;

  state_t r_state, state_nxt;

  // Synchronizer plus one extra stage for falling-edge detection.
  logic r_sync1, r_sync2, r_sync_d;

  logic [NCO_WIDTH-1:0] r_acc;
  logic [NCO_WIDTH:0]   w_acc_sum;
  logic                 w_tick;
  logic [3:0]           r_tick_cnt;

  logic                 r_s7, r_s8;
  logic                 w_vote, w_vote_pt, w_start_edge;

  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 w_stop_bad;
`ifdef UART_RX_BREAK_DET_EN
  logic                 r_par_zero;
`endif

  logic w_push_req, w_err_par, w_err_frm, w_err_brk;

  // FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_vld, w_full, w_pop, w_wr, w_ovr;

  assign w_acc_sum    = {1'b0, r_acc} + {1'b0, c_inc};
  assign w_tick       = w_acc_sum[NCO_WIDTH];
  assign w_start_edge = (r_state == ST_IDLE) && r_sync_d && !r_sync2;
  // Ticks 7 and 8 are registered; tick 9 is the live sample at the vote point.
  assign w_vote_pt    = w_tick && (r_tick_cnt == 4'd9);
  assign w_vote       = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
  assign w_stop_bad   = r_frame_err | ~w_vote;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next state and decision strobes. All state changes except IDLE->START
  // happen at a vote point; the tick counter free-runs mod 16 so the next
  // vote point is exactly one bit later. Strobes are forced low in reset so
  // no pulse escapes while the registers are being cleared.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = r_state;
    w_push_req = 1'b0;
    w_err_par  = 1'b0;
    w_err_frm  = 1'b0;
    w_err_brk  = 1'b0;
    if (rst) begin
      case (r_state)
        ST_IDLE: if (w_start_edge) state_nxt = ST_START;
        ST_START: if (w_vote_pt) state_nxt = w_vote ? ST_IDLE : ST_DATA;
        ST_DATA: if (w_vote_pt && (r_bit_idx == c_last_bit))
          state_nxt = (PARITY == 0) ? ST_STOP : ST_PARITY;
        ST_PARITY: if (w_vote_pt) state_nxt = ST_STOP;
        ST_STOP: if (w_vote_pt) begin
`ifdef UART_RX_BREAK_DET_EN
          if (!r_stop_idx && !w_vote && r_par_zero && (r_shift == '0)) begin
            w_err_brk = 1'b1;
            state_nxt = ST_BREAK_WAIT;
          end else
`endif
          if (r_stop_idx == c_last_stop) begin
            state_nxt = ST_IDLE;
            if (w_stop_bad || r_par_err) begin
              w_err_par = r_par_err;
              w_err_frm = w_stop_bad;
            end else begin
              w_push_req = 1'b1;
            end
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        ST_BREAK_WAIT: if (r_sync2) state_nxt = ST_IDLE;
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Synchronizer, oversampler and frame datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_d    <= 1'b1;
      r_acc       <= '0;
      r_tick_cnt  <= '0;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_par_zero  <= 1'b1;
`endif
    end else begin
      r_sync1  <= uart_rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;

      if (w_start_edge) begin
        // Re-phase the oversampler to the start edge.
        r_acc       <= '0;
        r_tick_cnt  <= '0;
        r_bit_idx   <= '0;
        r_stop_idx  <= 1'b0;
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        r_par_zero  <= 1'b1;
`endif
      end else begin
        r_acc <= w_acc_sum[NCO_WIDTH-1:0];
        if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
      end

      if (w_tick && (r_tick_cnt == 4'd7)) r_s7 <= r_sync2;
      if (w_tick && (r_tick_cnt == 4'd8)) r_s8 <= r_sync2;

      if (w_vote_pt) begin
        case (r_state)
          ST_DATA: begin
            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
          ST_PARITY: begin
            r_par_err  <= w_vote ^ (^r_shift) ^ c_odd;
`ifdef UART_RX_BREAK_DET_EN
            r_par_zero <= ~w_vote;
`endif
          end
          ST_STOP: begin
            if (!w_vote) r_frame_err <= 1'b1;
            r_stop_idx <= ~r_stop_idx;
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO. A pop requires vld, so push+pop on an empty FIFO is
  // naturally a plain push.
  // --------------------------------------------------------------------------
  assign w_vld  = (r_count != '0);
  assign w_full = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign w_pop  = w_vld && rdata_rdy;
  assign w_wr   = w_push_req && (!w_full || w_pop);
  assign w_ovr  = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata       = w_vld ? r_mem[r_rd_ptr] : '0;
  assign rdata_vld   = w_vld;
  assign fifo_count  = r_count;
  assign err_parity  = w_err_par;
  assign err_frame   = w_err_frm;
  assign err_overrun = w_ovr;
  assign err_break   = w_err_brk;
  assign uart_err    = w_err_par | w_err_frm | w_ovr | w_err_brk;

endmodule
`default_nettype wire
